// File: rtl/snes_pad_emulator_if.sv
// Console-port bundle for one pad emulator: routed buttons plus console latch/clock
// in, serial data and frame status out.
interface snes_pad_emulator_if;
  logic [11:0] buttons_in;
  logic        latch_in;
  logic        pclk_in;
  logic        data_out;
  logic        busy_out;
  logic        frame_done_out;
  logic        timeout_out;

  modport master (
    output buttons_in, latch_in, pclk_in,
    input  data_out, busy_out, frame_done_out, timeout_out
  );

  modport slave (
    input  buttons_in, latch_in, pclk_in,
    output data_out, busy_out, frame_done_out, timeout_out
  );
endinterface

// File: rtl/snes_pad_emulator.sv
// Serial SNES/NES controller emulator: answers console latch/clock polling with the
// routed active-low button vector, with a watchdog that abandons stalled frames.
module snes_pad_emulator #(
  parameter int NUM_BITS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic                clk_in,
  input  logic                reset_in,
  snes_pad_emulator_if.slave  pad
);

  localparam int BIT_W = $clog2(NUM_BITS);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pclk_sync_q;
  logic                   latch_prev_q;
  logic                   pclk_prev_q;
  logic                   latch_s;
  logic                   pclk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pclk_rise;

  state_t                 state_q;
  logic [NUM_BITS-1:0]    sr_q;
  logic [NUM_BITS-1:0]    load_vec;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [CNT_W-1:0]       to_cnt_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   timeout_q;

  // Idle levels (latch low, pclk high) so releasing reset does not fake an edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      latch_sync_q <= '0;
      pclk_sync_q  <= '1;
      latch_prev_q <= 1'b0;
      pclk_prev_q  <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.latch_in};
      pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], pad.pclk_in};
      latch_prev_q <= latch_s;
      pclk_prev_q  <= pclk_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pclk_s     = pclk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign pclk_rise  = pclk_s & ~pclk_prev_q;

  // Bits beyond the 12 buttons are released (1); an 8-bit NES port takes [7:0] only.
  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_load
    if (gi < 12) begin : g_btn
      assign load_vec[gi] = pad.buttons_in[gi];
    end else begin : g_fill
      assign load_vec[gi] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      sr_q         <= '1;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          sr_q <= '1;
          if (latch_rise) begin
            state_q <= LATCH;
            sr_q    <= load_vec;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          sr_q <= load_vec;
          if (latch_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end
        end
        SHIFT: begin
          if (latch_rise) begin
            state_q <= LATCH;
            sr_q    <= load_vec;
          end else if (pclk_rise && !latch_s) begin
            sr_q     <= {1'b1, sr_q[NUM_BITS-1:1]};
            to_cnt_q <= '0;
            if (bit_cnt_q == BIT_W'(NUM_BITS - 1)) begin
              state_q <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            sr_q      <= '1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DONE: begin
          // A latch arriving here restarts cleanly and suppresses the completion pulse.
          if (latch_rise) begin
            state_q <= LATCH;
            sr_q    <= load_vec;
          end else begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pad.data_out       = sr_q[0];
  assign pad.busy_out       = busy_q;
  assign pad.frame_done_out = frame_done_q;
  assign pad.timeout_out    = timeout_q;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Drives a 16-bit SNES and an 8-bit NES emulator from one shared console latch/clock
// and checks every serial bit and status pulse against a button-order model.
module tb_snes_pad_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch;
  logic        pclk;
  logic [11:0] s_btn;
  logic [11:0] n_btn;

  int vectors     = 0;
  int miscompares = 0;
  int s_done_cnt  = 0;
  int n_done_cnt  = 0;
  int s_to_cnt    = 0;
  int n_to_cnt    = 0;

  always #5 clk = ~clk;

  snes_pad_emulator_if sif ();
  snes_pad_emulator_if nif ();

  assign sif.buttons_in = s_btn;
  assign sif.latch_in   = latch;
  assign sif.pclk_in    = pclk;
  assign nif.buttons_in = n_btn;
  assign nif.latch_in   = latch;
  assign nif.pclk_in    = pclk;

  snes_pad_emulator #(.NUM_BITS(16)) u_snes (.clk_in(clk), .reset_in(rst), .pad(sif.slave));
  snes_pad_emulator #(.NUM_BITS(8))  u_nes  (.clk_in(clk), .reset_in(rst), .pad(nif.slave));

  always @(posedge clk) begin
    if (sif.frame_done_out) s_done_cnt <= s_done_cnt + 1;
    if (nif.frame_done_out) n_done_cnt <= n_done_cnt + 1;
    if (sif.timeout_out)    s_to_cnt   <= s_to_cnt + 1;
    if (nif.timeout_out)    n_to_cnt   <= n_to_cnt + 1;
  end

  // Bit k of a frame: button k while both the frame and the button list last, else released.
  function automatic logic exp_bit(input logic [11:0] b, input int nbits, input int k);
    if (k < nbits && k < 12) return b[k];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pclk_pulse();
    pclk = 1'b0;
    cyc(10);
    pclk = 1'b1;
    cyc(10);
  endtask

  task automatic do_frame(input logic [11:0] sb, input logic [11:0] nb, input int edges,
                          input int chg_at, input logic [11:0] sc, input logic [11:0] nc);
    int sd0, nd0, st0, nt0;
    logic [11:0] sf, nf;
    sd0 = s_done_cnt; nd0 = n_done_cnt; st0 = s_to_cnt; nt0 = n_to_cnt;
    s_btn = sb;
    n_btn = nb;
    cyc(2);
    latch = 1'b1;
    cyc(12);
    chk("s_busy_latch", sif.busy_out, 1);
    chk("n_busy_latch", nif.busy_out, 1);
    chk("s_live_bit0", sif.data_out, sb[0]);
    chk("n_live_bit0", nif.data_out, nb[0]);
    sf = sb;
    nf = nb;
    latch = 1'b0;
    cyc(10);
    for (int k = 0; k < edges; k++) begin
      chk($sformatf("s_bit%0d", k), sif.data_out, exp_bit(sf, 16, k));
      chk($sformatf("n_bit%0d", k), nif.data_out, exp_bit(nf, 8, k));
      if (k == 0) chk("s_busy_shift", sif.busy_out, 1);
      if (k == chg_at) begin
        s_btn = sc;
        n_btn = nc;
      end
      pclk_pulse();
      if (k == 7) begin
        chk("n_done_after8", n_done_cnt - nd0, 1);
        chk("n_busy_after8", nif.busy_out, 0);
      end
    end
    chk($sformatf("s_bit%0d", edges), sif.data_out, exp_bit(sf, 16, edges));
    chk($sformatf("n_bit%0d", edges), nif.data_out, exp_bit(nf, 8, edges));
    cyc(5);
    chk("s_done_cnt", s_done_cnt - sd0, (edges >= 16) ? 1 : 0);
    chk("n_done_cnt", n_done_cnt - nd0, (edges >= 8) ? 1 : 0);
    chk("s_no_timeout", s_to_cnt - st0, 0);
    chk("n_no_timeout", n_to_cnt - nt0, 0);
    if (edges >= 16) chk("s_busy_end", sif.busy_out, 0);
    $display("frame snes=%03h nes=%03h edges=%0d chg_at=%0d", sb, nb, edges, chg_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, nt0;
    logic [11:0] ra, rb;

    // Reset held while the console latches and clocks.
    rst   = 1'b1;
    latch = 1'b1;
    pclk  = 1'b1;
    s_btn = 12'h000;
    n_btn = 12'h000;
    for (int i = 0; i < 6; i++) begin
      pclk = ~pclk;
      cyc(3);
      chk("rst_s_data", sif.data_out, 1);
      chk("rst_s_busy", sif.busy_out, 0);
      chk("rst_s_pulses", {sif.frame_done_out, sif.timeout_out}, 0);
      chk("rst_n_data", nif.data_out, 1);
      chk("rst_n_busy", nif.busy_out, 0);
    end
    latch = 1'b0;
    pclk  = 1'b1;
    cyc(2);
    rst = 1'b0;
    repeat (3) begin
      pclk_pulse();
      chk("idle_s_data", sif.data_out, 1);
      chk("idle_s_busy", sif.busy_out, 0);
      chk("idle_n_busy", nif.busy_out, 0);
    end
    $display("reset sequence done");

    do_frame(12'hFFE, 12'hFFE, 16, -1, 12'h000, 12'h000);
    do_frame(12'h5A5, 12'h3C3, 16, 6, 12'h000, 12'h000);
    do_frame(12'hFFF, 12'hFFF, 16, -1, 12'h000, 12'h000);

    // Abort after 5 edges, then a full frame must restart at bit 0.
    ra = 12'($urandom);
    rb = 12'($urandom);
    do_frame(ra, rb, 5, -1, 12'h000, 12'h000);
    ra = 12'($urandom);
    rb = 12'($urandom);
    do_frame(ra, rb, 16, -1, 12'h000, 12'h000);

    // Stall after 3 edges: the watchdog abandons both frames.
    st0 = s_to_cnt;
    nt0 = n_to_cnt;
    do_frame(12'hA5A, 12'h0F0, 3, -1, 12'h000, 12'h000);
    cyc(3950);
    chk("s_timeout_early", s_to_cnt - st0, 0);
    chk("n_timeout_early", n_to_cnt - nt0, 0);
    chk("s_busy_stall", sif.busy_out, 1);
    for (int i = 0; i < 400; i++) begin
      if ((s_to_cnt - st0) >= 1 && (n_to_cnt - nt0) >= 1) break;
      cyc(1);
    end
    cyc(3);
    chk("s_timeout_pulse", s_to_cnt - st0, 1);
    chk("n_timeout_pulse", n_to_cnt - nt0, 1);
    chk("s_data_after_to", sif.data_out, 1);
    chk("n_data_after_to", nif.data_out, 1);
    chk("s_busy_after_to", sif.busy_out, 0);
    chk("n_busy_after_to", nif.busy_out, 0);
    $display("timeout sequence done");

    for (int r = 0; r < 3; r++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      do_frame(ra, rb, 16, (r == 1) ? 9 : -1, 12'($urandom), 12'($urandom));
    end

    // Asynchronous reset mid-frame.
    s_btn = 12'h000;
    n_btn = 12'h000;
    cyc(2);
    latch = 1'b1;
    cyc(12);
    latch = 1'b0;
    cyc(10);
    pclk_pulse();
    pclk_pulse();
    chk("mid_s_bit2", sif.data_out, 0);
    chk("mid_s_busy", sif.busy_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_s_data", sif.data_out, 1);
    chk("async_s_busy", sif.busy_out, 0);
    chk("async_n_data", nif.data_out, 1);
    cyc(3);
    rst = 1'b0;
    cyc(20);
    chk("post_rst_s_busy", sif.busy_out, 0);
    chk("post_rst_s_data", sif.data_out, 1);
    $display("mid-frame reset done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
